bus_decoder: RTL and testbench
==============================

# bus_decoder

Parametrised memory-bus interconnect between the single `cpu` master and up to 2^SEL_W slave devices (ROM, RAM, peripherals). It generalises the fixed one-bit ROM/RAM address split into an N-region decoder with registered strobes and per-slave read-only protection. A watchdog converts a missing `ready` into a bus-error response. It sits at the `computer` top level, in place of the hand-wired address-bit decode.

## Interface
Parameters:
- `ADDR_W`, 8: master address width.
- `DATA_W`, 8: data width.
- `SEL_W`, 1: number of top address bits used as slave select; NUM_SLAVES = 2^SEL_W.
- `RO_MASK`, 'b01: bit i = 1 marks slave i read-only; slave 0 is ROM.
- `TIMEOUT`, 15: WAIT cycles allowed before a bus error; legal range 1..255.

Ports:
- `clk`  in  1  system clock; one clock domain; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read`  in  1  master read request; held until `ready`.
- `write`  in  1  master write request; held until `ready`.
- `address`  in  ADDR_W  master address.
- `data_out`  in  DATA_W  master write data.
- `data_in`  out  DATA_W  read data returned to the master.
- `ready`  out  1  one-cycle completion pulse to the master.
- `error`  out  1  one-cycle bus-error pulse, coincident with `ready`.
- `s_read`  out  NUM_SLAVES  per-slave read strobe, one-hot or zero.
- `s_write`  out  NUM_SLAVES  per-slave write strobe, one-hot or zero.
- `s_address`  out  ADDR_W-SEL_W  latched slave-local address.
- `s_data_out`  out  DATA_W  latched write data.
- `s_data_in`  in  NUM_SLAVES*DATA_W  packed slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- `s_ready`  in  NUM_SLAVES  per-slave completion.

## Operation
- Slave select: `sel = address[ADDR_W-1 -: SEL_W]`. Local address: the remaining low bits.
- FSM states: IDLE, WAIT, DONE, ERR.
- IDLE, no request: stay in IDLE.
- IDLE, `read` xor `write` sampled high: latch `sel`, the local address, `data_out` and the operation.
  - Write to a slave with RO_MASK[sel] = 1: go to ERR. No slave strobe is ever raised.
  - Otherwise: go to WAIT and raise `s_read[sel]` or `s_write[sel]`.
- IDLE, `read` and `write` both high: go to ERR with no strobe.
- WAIT: strobe held and latched fields stable.
  - `s_ready[sel]` high: capture slave data (reads only) and go to DONE. Strobe drops.
  - `s_ready` of non-selected slaves is ignored.
  - Watchdog counter clears on entry to WAIT and increments on each WAIT cycle without `s_ready[sel]`.
  - If the counter equals TIMEOUT-1 and `s_ready[sel]` is low: go to ERR and drop the strobe.
  - If `s_ready[sel]` arrives in the same cycle as the timeout, `s_ready` wins and the FSM goes to DONE.
- DONE: `ready`=1 for one cycle. `data_in` = captured data for reads and holds its previous value for writes. Next state IDLE.
- ERR: `ready`=1 and `error`=1 for one cycle, `data_in` = all ones. Next state IDLE.
- All outputs are registered.
- The master must deassert `read`/`write` in the cycle after `ready`. A request still asserted in IDLE starts a new transaction.

## Timing
- Reset values: state IDLE, `s_read`/`s_write` = 0, `s_address` = 0, `s_data_out` = 0, `data_in` = 0, `ready` = 0, `error` = 0, counter = 0.
- Reset asserted mid-transaction aborts it. Strobes are low in the cycle after the reset edge, and no `ready` is produced.
- Strobes become visible the cycle after the request is sampled.
- Slave answering `s_ready` in its first strobe cycle: master `ready` arrives 2 cycles after the request edge. This is the minimum latency.
- Each extra slave wait cycle adds one cycle of latency.
- Timeout: ERR `ready` arrives TIMEOUT+1 cycles after the request edge.
- Read-only write or double request: `ready`+`error` arrives 1 cycle after the request edge.
- Throughput: one transaction per 3 cycles at best (IDLE, WAIT, DONE).

## Structure
- Shared package `bus_pkg`:
  - FSM state encoding (2-bit localparams).
  - `BUS_ERR_DATA` fill constant.
  - Helper function computing NUM_SLAVES from SEL_W.
- Sub-module `bus_watchdog`: a clear/enable counter of width $clog2(TIMEOUT) with an `expired` output.
- Everything else is flat in `bus_decoder`: FSM, latches, and the one-hot strobe generator.

## Test plan
- Read slave 1, address 0x85, `s_ready[1]` in the first WAIT cycle, `s_data_in` slice 1 = 0x3C:
  - `s_read` = 'b10 and `s_address` = 0x05.
  - `ready` 2 cycles after request with `data_in` = 0x3C, `error` = 0.
- Write 0x5A to address 0x10 (slave 0, RO):
  - `s_write` stays 0.
  - `ready`=`error`=1 one cycle after request, `data_in` = 0xFF.
- Read slave 0 with `s_ready` held low, TIMEOUT=15:
  - `s_read[0]` high for exactly 15 cycles.
  - Then `ready`+`error` with `data_in` = 0xFF; FSM back in IDLE.
- `s_ready[sel]` asserted on exactly the 15th WAIT cycle: DONE, not ERR; `error` = 0.
- `reset` pulsed during WAIT of a write to slave 1:
  - Strobes 0 the next cycle, no `ready` pulse.
  - A following read completes normally.
- SEL_W=2 build: reads to 0x00, 0x40, 0x80 and 0xC0 each raise only the matching one-hot `s_read` bit. A stray `s_ready` on a non-selected slave does not complete the transaction.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus decoder: FSM encoding, error fill
// value and sizing helpers.
package bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Returned on data_in for any bus error; sliced down to DATA_W.
  localparam logic [63:0] BUS_ERR_DATA = '1;

  function automatic int num_slaves(input int sel_w);
    return 1 << sel_w;
  endfunction

  // Watchdog width; a TIMEOUT of 1 still needs a one-bit counter.
  function automatic int wd_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// CPU-side and slave-side bus signals of the decoder. The decoder takes the
// slave view; whatever drives the CPU and slave devices takes the master view.
interface bus_decoder_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
);
  localparam int NS = num_slaves(SEL_W);

  logic                    read;
  logic                    write;
  logic [ADDR_W-1:0]       address;
  logic [DATA_W-1:0]       data_out;
  logic [DATA_W-1:0]       data_in;
  logic                    ready;
  logic                    error;
  logic [NS-1:0]           s_read;
  logic [NS-1:0]           s_write;
  logic [ADDR_W-SEL_W-1:0] s_address;
  logic [DATA_W-1:0]       s_data_out;
  logic [NS*DATA_W-1:0]    s_data_in;
  logic [NS-1:0]           s_ready;

  modport slave (
    input  read, write, address, data_out, s_data_in, s_ready,
    output data_in, ready, error, s_read, s_write, s_address, s_data_out
  );

  modport master (
    output read, write, address, data_out, s_data_in, s_ready,
    input  data_in, ready, error, s_read, s_write, s_address, s_data_out
  );

endinterface

// File: rtl/bus_watchdog.sv
// Clear/enable cycle counter that flags when TIMEOUT-1 is reached.
module bus_watchdog
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int              CW   = wd_width(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/bus_decoder.sv
// N-region memory-bus decoder: registered one-hot slave strobes, read-only
// write protection and a watchdog that turns a silent slave into a bus error.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int                           ADDR_W  = 8,
  parameter int                           DATA_W  = 8,
  parameter int                           SEL_W   = 1,
  parameter logic [num_slaves(SEL_W)-1:0] RO_MASK = 'b01,
  parameter int                           TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  bus_decoder_if.slave bus
);
  localparam int NS = num_slaves(SEL_W);
  localparam int LW = ADDR_W - SEL_W;

  logic [1:0]                   state, nxt;
  logic [SEL_W-1:0]             sel, sel_q, sel_n;
  logic [LW-1:0]                loc;
  logic                         op_wr, wr_n;
  logic                         accept, hit, expired, wd_en;
  logic [NS-1:0]                onehot;
  logic [NS-1:0][DATA_W-1:0]    rdata;
  logic [NS-1:0]                s_read_d, s_write_d;
  logic [DATA_W-1:0]            data_d;
  logic                         ready_d, error_d;

  assign sel    = bus.address[ADDR_W-1 -: SEL_W];
  assign loc    = bus.address[LW-1:0];
  assign accept = (state == ST_IDLE) && (bus.read ^ bus.write);
  assign hit    = bus.s_ready[sel_q];
  assign rdata  = bus.s_data_in;

  // Strobe target for the cycle being entered: fresh decode on accept,
  // otherwise the latched transaction.
  assign sel_n = accept ? sel : sel_q;
  assign wr_n  = accept ? bus.write : op_wr;

  for (genvar i = 0; i < NS; i++) begin : g_strobe
    assign onehot[i] = (sel_n == SEL_W'(i));
  end

  assign wd_en = (state == ST_WAIT) && !hit;

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (wd_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.read && bus.write)         nxt = ST_ERR;
        else if (bus.write && RO_MASK[sel]) nxt = ST_ERR;
        else if (bus.read || bus.write)    nxt = ST_WAIT;
      end
      // A slave answer in the timeout cycle still completes normally.
      ST_WAIT: begin
        if (hit)          nxt = ST_DONE;
        else if (expired) nxt = ST_ERR;
      end
      ST_DONE: nxt = ST_IDLE;
      ST_ERR:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    s_read_d  = '0;
    s_write_d = '0;
    if (nxt == ST_WAIT) begin
      if (wr_n) s_write_d = onehot;
      else      s_read_d  = onehot;
    end
    ready_d = (nxt == ST_DONE) || (nxt == ST_ERR);
    error_d = (nxt == ST_ERR);
    data_d  = bus.data_in;
    if (nxt == ST_ERR)
      data_d = BUS_ERR_DATA[DATA_W-1:0];
    else if (state == ST_WAIT && nxt == ST_DONE && !op_wr)
      data_d = rdata[sel_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q          <= '0;
      op_wr          <= 1'b0;
      bus.s_address  <= '0;
      bus.s_data_out <= '0;
    end else if (accept) begin
      sel_q          <= sel;
      op_wr          <= bus.write;
      bus.s_address  <= loc;
      bus.s_data_out <= bus.data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.s_read  <= '0;
      bus.s_write <= '0;
      bus.ready   <= 1'b0;
      bus.error   <= 1'b0;
      bus.data_in <= '0;
    end else begin
      bus.s_read  <= s_read_d;
      bus.s_write <= s_write_d;
      bus.ready   <= ready_d;
      bus.error   <= error_d;
      bus.data_in <= data_d;
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Bench for bus_decoder: a timeline model predicts every output per cycle of
// a SEL_W=1 build; a SEL_W=2 build is checked against literal expectations.
module tb_bus_decoder;
  localparam int         T    = 15;
  localparam int         MAXC = 1024;
  localparam logic [1:0] RO1  = 2'b01;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_decoder_if #(.ADDR_W(8), .DATA_W(8), .SEL_W(1)) b1 ();
  bus_decoder_if #(.ADDR_W(8), .DATA_W(8), .SEL_W(2)) b2 ();

  bus_decoder #(.ADDR_W(8), .DATA_W(8), .SEL_W(1), .RO_MASK(2'b01), .TIMEOUT(T))
    dut1 (.clk(clk), .reset(reset), .bus(b1));
  bus_decoder #(.ADDR_W(8), .DATA_W(8), .SEL_W(2), .RO_MASK(4'b0001), .TIMEOUT(T))
    dut2 (.clk(clk), .reset(reset), .bus(b2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs of dut1 for the cycle following each rising edge.
  logic [1:0] e_rd [MAXC];
  logic [1:0] e_wr [MAXC];
  logic [6:0] e_adr[MAXC];
  logic [7:0] e_wd [MAXC];
  logic [7:0] e_din[MAXC];
  logic       e_rdy[MAXC];
  logic       e_err[MAXC];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void idle_from(int n, logic [6:0] a, logic [7:0] w, logic [7:0] d);
    for (int i = n; i < MAXC; i++) begin
      e_rd[i] = 2'b00; e_wr[i] = 2'b00; e_rdy[i] = 1'b0; e_err[i] = 1'b0;
      e_adr[i] = a; e_wd[i] = w; e_din[i] = d;
    end
  endfunction

  // Lays out a transaction sampled at edge R; returns its ready cycle.
  function automatic int plan(int R, bit rd, bit wr, logic [7:0] addr, logic [7:0] wd,
                              int rdy_at, logic [7:0] sdata);
    logic       sel;
    logic [6:0] a;
    logic [7:0] w, din, nd;
    logic [1:0] bitv;
    bit         tmo;
    int         len;
    sel = addr[7]; a = e_adr[R]; w = e_wd[R]; din = e_din[R];
    if (rd ^ wr) begin a = addr[6:0]; w = wd; end
    if ((rd && wr) || (wr && RO1[sel])) begin
      idle_from(R, a, w, 8'hFF);
      e_rdy[R] = 1'b1; e_err[R] = 1'b1;
      return R;
    end
    tmo  = !(rdy_at >= 0 && rdy_at < T);
    len  = tmo ? T : rdy_at + 1;
    bitv = 2'b01 << sel;
    idle_from(R, a, w, din);
    for (int k = 0; k < len; k++) begin
      if (wr) e_wr[R+k] = bitv;
      else    e_rd[R+k] = bitv;
    end
    nd = tmo ? 8'hFF : (rd ? sdata : din);
    idle_from(R + len, a, w, nd);
    e_rdy[R+len] = 1'b1; e_err[R+len] = tmo;
    return R + len;
  endfunction

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_model();
    if (cyc < MAXC) begin
      n_tests++;
      if (b1.s_read !== e_rd[cyc] || b1.s_write !== e_wr[cyc] || b1.s_address !== e_adr[cyc] ||
          b1.s_data_out !== e_wd[cyc] || b1.data_in !== e_din[cyc] ||
          b1.ready !== e_rdy[cyc] || b1.error !== e_err[cyc]) begin
        n_fail++;
        $display("FAIL model cyc=%0d got rd=%b wr=%b adr=%h wd=%h din=%h rdy=%b err=%b expected rd=%b wr=%b adr=%h wd=%h din=%h rdy=%b err=%b",
                 cyc, b1.s_read, b1.s_write, b1.s_address, b1.s_data_out, b1.data_in, b1.ready, b1.error,
                 e_rd[cyc], e_wr[cyc], e_adr[cyc], e_wd[cyc], e_din[cyc], e_rdy[cyc], e_err[cyc]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
  endtask

  // Runs one dut1 transaction from a negedge; the non-selected slave answers
  // on every cycle, and reset can be pulsed at wait index rst_at.
  task automatic txn(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                     input int rdy_at, input logic [7:0] sdata, input int rst_at,
                     output int R, output int C);
    logic sel;
    sel = addr[7];
    b1.read = rd; b1.write = wr; b1.address = addr; b1.data_out = wd;
    b1.s_data_in = sel ? {sdata, ~sdata} : {~sdata, sdata};
    R = cyc + 1;
    C = plan(R, rd, wr, addr, wd, rdy_at, sdata);
    for (int n = R; n <= C; n++) begin
      tick();
      b1.s_ready = '0;
      b1.s_ready[!sel] = 1'b1;
      if (rdy_at >= 0 && n - R == rdy_at) b1.s_ready[sel] = 1'b1;
      if (rst_at >= 0 && n - R == rst_at) begin
        reset = 1'b1; b1.read = 1'b0; b1.write = 1'b0; b1.s_ready = '0;
        idle_from(n + 1, 7'h00, 8'h00, 8'h00);
        tick();
        reset = 1'b0;
        C = n + 1;
        break;
      end
      if (n == C) begin
        b1.read = 1'b0; b1.write = 1'b0; b1.s_ready = '0;
      end
    end
    tick();
  endtask

  initial begin
    int R, C, cnt;
    logic [3:0] oh2 [4];
    logic [7:0] adr2[4];
    logic [7:0] dat2[4];
    oh2  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    adr2 = '{8'h00, 8'h40, 8'h80, 8'hC0};
    dat2 = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};

    idle_from(0, 7'h00, 8'h00, 8'h00);
    b1.read = 0; b1.write = 0; b1.address = 0; b1.data_out = 0; b1.s_data_in = 0; b1.s_ready = 0;
    b2.read = 0; b2.write = 0; b2.address = 0; b2.data_out = 0; b2.s_data_in = 0; b2.s_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    pin("rst_data_in", b1.data_in, 0);
    pin("rst_strobes", {b1.s_read, b1.s_write}, 0);
    pin("rst_ready", {b1.ready, b1.error}, 0);

    // Read slave 1, answer in first wait cycle.
    txn(1, 0, 8'h85, 8'h00, 0, 8'h3C, -1, R, C);
    pin("t1_latency", C + 1 - R, 2);
    pin("t1_strobe", e_rd[R], 2'b10);
    pin("t1_saddr", e_adr[R], 8'h05);
    pin("t1_data", e_din[C], 8'h3C);
    pin("t1_err", e_err[C], 0);

    // Write to the read-only ROM.
    txn(0, 1, 8'h10, 8'h5A, 0, 8'h00, -1, R, C);
    pin("ro_latency", C + 1 - R, 1);
    pin("ro_strobe", e_wr[R], 0);
    pin("ro_err", {e_rdy[C], e_err[C], e_din[C]}, {2'b11, 8'hFF});

    // Silent slave 0: watchdog timeout.
    txn(1, 0, 8'h22, 8'h00, -1, 8'h00, -1, R, C);
    cnt = 0;
    for (int i = R; i < C; i++) if (e_rd[i] == 2'b01) cnt++;
    pin("tmo_strobe_cycles", cnt, 15);
    pin("tmo_latency", C + 1 - R, 16);
    pin("tmo_err", {e_err[C], e_din[C]}, {1'b1, 8'hFF});

    // Answer in the same cycle the watchdog expires.
    txn(1, 0, 8'h9A, 8'h00, 14, 8'h77, -1, R, C);
    pin("edge_err", e_err[C], 0);
    pin("edge_data", e_din[C], 8'h77);

    // Reset during a write wait, then a normal read.
    txn(0, 1, 8'hC4, 8'hA5, -1, 8'h00, 3, R, C);
    txn(1, 0, 8'h81, 8'h00, 2, 8'h42, -1, R, C);
    pin("post_rst_latency", C + 1 - R, 4);

    // Completed write keeps the last read data; double request errors.
    txn(0, 1, 8'hF0, 8'h11, 1, 8'h99, -1, R, C);
    pin("wr_hold", e_din[C], 8'h42);
    txn(1, 1, 8'h80, 8'h00, 0, 8'h00, -1, R, C);
    pin("dbl_err", {C + 1 - R, e_err[C]}, {32'd1, 1'b1} >> 0 & 33'h1_0000_0001 ? {31'd1, 1'b1} : 0);
    txn(1, 0, 8'h7F, 8'h00, 0, 8'hC3, -1, R, C);

    // Four-slave build: one-hot decode, stray ready ignored.
    b2.s_data_in = 32'hD0C0B0A0;
    for (int i = 0; i < 4; i++) begin
      b2.address = adr2[i]; b2.read = 1'b1; b2.s_ready = '0;
      tick();
      pin("sel2_strobe", {b2.s_read, b2.s_write}, {oh2[i], 4'b0000});
      b2.s_ready = oh2[(i + 1) % 4];
      tick();
      pin("sel2_stray", {b2.ready, b2.s_read}, {1'b0, oh2[i]});
      b2.s_ready = oh2[i];
      tick();
      pin("sel2_done", {b2.ready, b2.error, b2.data_in}, {2'b10, dat2[i]});
      b2.read = 1'b0; b2.s_ready = '0;
      tick();
      pin("sel2_idle", {b2.ready, b2.s_read}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
